// File: rtl/shift_reg_rx_pkg.sv
// Shared types and frame-size helpers for the serial shift-register receiver.
// SHIFT_RX_PARITY_EN adds one trailing even-parity bit to every frame.
package shift_reg_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_WAIT_END = 2'd2
  } state_e;

`ifdef SHIFT_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  function automatic int frameBits(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/shift_reg_rx_bit_sync.sv
// Multi-flop synchroniser for one asynchronous input pin, with a selectable reset level.
module shift_reg_rx_bit_sync #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstN_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/shift_reg_rx.sv
// Receive end of the serial shift-register link: oversamples SCLK/SDI/CS_N and delivers words on valid/ready.
// Optional feature macro: SHIFT_RX_PARITY_EN (trailing even-parity bit and PARITY_ERR port).
module shift_reg_rx
  import shift_reg_rx_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SCLK,
  input  logic             SDI,
  input  logic             CS_N,
  output logic [WIDTH-1:0] DATA_out,
  output logic             VALID_out,
  input  logic             READY_in,
  output logic             FRAME_ERR,
`ifdef SHIFT_RX_PARITY_EN
  output logic             PARITY_ERR,
`endif
  output logic             OVERRUN
);

  localparam int FRAME_BITS = frameBits(WIDTH);
  localparam int CNT_W      = $clog2(WIDTH + 2);

  logic sclkSync, sdiSync, csnSync;

  shift_reg_rx_bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) sclkSyncInst (
    .clk_i(CLK), .rstN_i(RST_N), .d_i(SCLK), .q_o(sclkSync));
  shift_reg_rx_bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) sdiSyncInst (
    .clk_i(CLK), .rstN_i(RST_N), .d_i(SDI), .q_o(sdiSync));
  shift_reg_rx_bit_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) csnSyncInst (
    .clk_i(CLK), .rstN_i(RST_N), .d_i(CS_N), .q_o(csnSync));

  logic                  sclkPrev_q, sclkRise_q, sdiRise_q;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  commit, frameErr;
  logic [WIDTH-1:0]      word;
  logic [WIDTH-1:0]      data_q;
  logic                  valid_q, frameErr_q, overrun_q;

  // The SDI sample is captured alongside the registered edge so both stay aligned.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclkPrev_q <= 1'b0;
      sclkRise_q <= 1'b0;
      sdiRise_q  <= 1'b0;
    end else begin
      sclkPrev_q <= sclkSync;
      sclkRise_q <= sclkSync & ~sclkPrev_q;
      sdiRise_q  <= sdiSync;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    commit   = 1'b0;
    frameErr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bitCnt_d = '0;
        shift_d  = '0;
        if (!csnSync) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclkRise_q) begin
          shift_d  = (MSB_FIRST != 0) ? {shift_q[FRAME_BITS-2:0], sdiRise_q}
                                      : {sdiRise_q, shift_q[FRAME_BITS-1:1]};
          bitCnt_d = bitCnt_q + CNT_W'(1);
          // A final bit arriving together with CS_N release still completes the frame.
          if (bitCnt_q == CNT_W'(FRAME_BITS - 1)) begin
            commit  = 1'b1;
            state_d = csnSync ? ST_IDLE : ST_WAIT_END;
          end else if (csnSync) begin
            frameErr = 1'b1;
            state_d  = ST_IDLE;
          end
        end else if (csnSync) begin
          frameErr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT_END: begin
        if (csnSync) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign word = (MSB_FIRST != 0) ? shift_d[FRAME_BITS-1 -: WIDTH] : shift_d[WIDTH-1:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= frameErr;
      overrun_q  <= commit & valid_q & ~READY_in;
      if (commit && (!valid_q || READY_in)) begin
        data_q  <= word;
        valid_q <= 1'b1;
      end else if (valid_q && READY_in) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SHIFT_RX_PARITY_EN
  logic parityErr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      parityErr_q <= 1'b0;
    end else begin
      parityErr_q <= commit & (^shift_d);
    end
  end

  assign PARITY_ERR = parityErr_q;
`endif

  assign DATA_out  = data_q;
  assign VALID_out = valid_q;
  assign FRAME_ERR = frameErr_q;
  assign OVERRUN   = overrun_q;

endmodule
